interrupter_pulse_gen: RTL
==========================

// Module: interrupter_pulse_gen
// PURPOSE
//  Tesla-coil interrupter timing stage downstream of the clock divider.
//  Consumes the divider's single-cycle tick_en strobe as its time base and produces the gate
//  window (on-time / off-time) that enables the bridge driver.
//  On-time is clamped against a safety maximum and off-time against a minimum. Configuration is
//  double-buffered and applied only at period boundaries. A fault input kills the gate immediately.
// PARAMETERS
//  CNT_W          16   width of period/on-time fields and phase counter (ticks)
//  MAX_ON_TICKS   200  hard ceiling on applied on-time, in ticks
//  MIN_OFF_TICKS  10   hard floor on applied off-time, in ticks
// PORTS
//  clock_in      in   1      system clock
//  reset_n       in   1      asynchronous, active-low reset
//  tick_en       in   1      time-base strobe from clock divider, 1 cycle wide
//  enable        in   1      run request, level
//  cfg_valid     in   1      new config offered
//  cfg_ready     out  1      staging register empty, config accepted on valid&ready
//  cfg_period    in   CNT_W  period in ticks; 0 = stop
//  cfg_on        in   CNT_W  requested on-time in ticks
//  fault         in   1      external fault, level, highest priority
//  fault_clear   in   1      releases FAULT when fault is low
//  gate          out  1      interrupter output to bridge enable
//  period_start  out  1      1-cycle pulse on the cycle gate rises
//  faulted       out  1      high while in FAULT
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - gate=0, period_start=0, faulted=0, cfg_ready=1.
//   - Active config on=off=0, which means stopped. Staging empty. State IDLE. Counter=0.
//  Config handshake:
//   - On cfg_valid&cfg_ready, capture {period,on} into staging and set pending.
//   - cfg_ready=0 while pending.
//   - Pending transfers to active in IDLE on any cycle, or at the OFF->ON/IDLE boundary tick.
//   - cfg_ready returns to 1 the cycle after transfer.
//   - Staging persists through FAULT.
//  Clamping at transfer (CNT_W-bit unsigned, no overflow):
//   - on_eff = min(cfg_on, MAX_ON_TICKS).
//   - off_eff = (period > on_eff) ? max(period - on_eff, MIN_OFF_TICKS) : MIN_OFF_TICKS.
//   - period==0 or on_eff==0: config is stopped; on_eff=0.
//  States, with counter loaded at entry and decremented on tick_en:
//   - IDLE: gate=0. Go to ON on tick_en & enable & on_eff!=0 (using config active that cycle).
//   - ON: gate=1.
//     - Counter==1 & tick_en -> OFF, load off_eff.
//     - enable falls -> OFF next cycle, load off_eff (min off always honoured).
//   - OFF: gate=0. Counter==1 & tick_en: apply pending, then
//     - enable & on_eff!=0 -> ON (period_start pulses);
//     - else -> IDLE.
//   - FAULT: gate=0, faulted=1, counter held 0. Go to IDLE on fault_clear & ~fault.
//  Fault priority:
//   - fault=1 in any state -> FAULT next cycle.
//   - gate = gate_q & ~fault, so the kill is combinational in the same cycle.
//  Timing:
//   - gate and period_start are registered and rise the cycle after the starting tick_en.
//   - Gate high lasts exactly on_eff tick intervals.
//  Simultaneous events:
//   - fault beats everything.
//   - cfg accept and transfer in the same cycle: transfer uses the old staging; the new value
//     becomes pending.
//   - tick_en ignored while reset_n=0.
//  Wrap: counter never underflows; it is only decremented when nonzero.
// STRUCTURE
//  Package interrupter_pkg:
//   - state_t enum {IDLE,ON,OFF,FAULT}.
//   - typedef cfg_t struct {period,on}.
//   - CNT_W default constant.
//  Sub-module interrupter_cfg_shadow: staging register, valid/ready handshake, clamp arithmetic,
//  active register, transfer strobe input.
// TESTING
//  - Tick every 4 clk, cfg{period=20,on=5}, enable=1 -> gate high 20 clk, low 60 clk, repeating;
//    period_start once per 80 clk.
//  - cfg_on=500 -> on clamped to 200 ticks.
//    cfg{period=100,on=95} -> off=10 ticks (MIN_OFF).
//  - Mid-ON, new cfg{30,10} -> cfg_ready=0 until end of current OFF; next period uses 10/20.
//  - fault=1 mid-ON -> gate=0 same cycle, faulted=1 next.
//    fault_clear while fault=1 ignored; after fault=0 & fault_clear -> IDLE, restart on next tick.
//  - enable falls 2 ticks into a 5-tick ON -> gate low next cycle; full off_eff honoured; then IDLE.
//  - reset_n pulsed low mid-ON between clock edges -> gate=0 immediately, cfg_ready=1,
//    no restart until new cfg.

Source files
------------

// File: rtl/interrupter_pkg.sv
// Shared types and clamp helper for the interrupter timing stage.
// Field widths follow CNT_W_DEF; the top must be built with CNT_W equal to it.
package interrupter_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    FAULT
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] on;
  } cfg_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] on_eff;
    logic [CNT_W_DEF-1:0] off_eff;
  } act_t;

  // A zero period or a zero on-time means stopped, so on_eff is forced to 0.
  function automatic act_t clamp_cfg(
    input cfg_t                 c,
    input logic [CNT_W_DEF-1:0] max_on,
    input logic [CNT_W_DEF-1:0] min_off
  );
    act_t                 res;
    logic [CNT_W_DEF-1:0] diff;
    res.on_eff = (c.on > max_on) ? max_on : c.on;
    if (c.period == '0) begin
      res.on_eff = '0;
    end
    diff = c.period - res.on_eff;
    if (c.period > res.on_eff) begin
      res.off_eff = (diff > min_off) ? diff : min_off;
    end else begin
      res.off_eff = min_off;
    end
    return res;
  endfunction

endpackage

// File: rtl/interrupter_cfg_shadow.sv
// Double-buffered config: staging register with valid/ready intake, clamped active register.
// Transfer takes one edge; ready stays low while a staged config is waiting for a boundary.
module interrupter_cfg_shadow
  import interrupter_pkg::*;
#(
  parameter int MAX_ON_TICKS  = 200,
  parameter int MIN_OFF_TICKS = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cfg_vld,
  output logic o_cfg_rdy,
  input  cfg_t i_cfg_dat,
  input  logic i_xfer_win,
  output act_t o_act_dat,
  output act_t o_nxt_dat
);

  localparam logic [CNT_W_DEF-1:0] MAX_ON  = CNT_W_DEF'(MAX_ON_TICKS);
  localparam logic [CNT_W_DEF-1:0] MIN_OFF = CNT_W_DEF'(MIN_OFF_TICKS);

  cfg_t r_stage;
  logic r_pend;
  act_t r_act;

  logic w_accept;
  logic w_xfer;
  act_t w_clamped;

  assign w_accept  = i_cfg_vld & ~r_pend;
  assign w_xfer    = i_xfer_win & r_pend;
  assign w_clamped = clamp_cfg(r_stage, MAX_ON, MIN_OFF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage <= '0;
      r_pend  <= 1'b0;
      r_act   <= '0;
    end else begin
      if (w_xfer) begin
        r_act <= w_clamped;
      end
      // A same-cycle accept re-arms pending with the new value after the old one moves out.
      if (w_accept) begin
        r_stage <= i_cfg_dat;
        r_pend  <= 1'b1;
      end else if (w_xfer) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_cfg_rdy = ~r_pend;
  assign o_act_dat = r_act;
  assign o_nxt_dat = w_xfer ? w_clamped : r_act;

endmodule

// File: rtl/interrupter_pulse_gen.sv
// Interrupter gate window generator driven by the divider tick; gate/period_start registered,
// fault kills gate combinationally. Config intake backpressures via cfg_ready until a period boundary.
module interrupter_pulse_gen
  import interrupter_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int MAX_ON_TICKS  = 200,
  parameter int MIN_OFF_TICKS = 10
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             tick_en,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic             fault,
  input  logic             fault_clear,
  output logic             gate,
  output logic             period_start,
  output logic             faulted
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gate;
  logic             r_period_start;
  logic             r_faulted;

  cfg_t w_cfg_dat;
  act_t w_act;
  act_t w_nxt;
  logic w_tick_end;
  logic w_xfer_win;

  assign w_cfg_dat  = '{period: cfg_period, on: cfg_on};
  assign w_tick_end = tick_en & (r_cnt == CNT_W'(1));
  assign w_xfer_win = ~fault & ((r_state == IDLE) | ((r_state == OFF) & w_tick_end));

  interrupter_cfg_shadow #(
    .MAX_ON_TICKS (MAX_ON_TICKS),
    .MIN_OFF_TICKS(MIN_OFF_TICKS)
  ) u_cfg_shadow (
    .i_clk     (clock_in),
    .i_rst_n   (reset_n),
    .i_cfg_vld (cfg_valid),
    .o_cfg_rdy (cfg_ready),
    .i_cfg_dat (w_cfg_dat),
    .i_xfer_win(w_xfer_win),
    .o_act_dat (w_act),
    .o_nxt_dat (w_nxt)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_gate         <= 1'b0;
      r_period_start <= 1'b0;
      r_faulted      <= 1'b0;
    end else if (fault) begin
      r_state        <= FAULT;
      r_cnt          <= '0;
      r_gate         <= 1'b0;
      r_period_start <= 1'b0;
      r_faulted      <= 1'b1;
    end else begin
      r_period_start <= 1'b0;
      case (r_state)
        IDLE: begin
          // Start decision uses the active config as it stands this cycle.
          if (tick_en & enable & (w_act.on_eff != '0)) begin
            r_state        <= ON;
            r_cnt          <= w_act.on_eff;
            r_gate         <= 1'b1;
            r_period_start <= 1'b1;
          end
        end
        ON: begin
          if (w_tick_end | ~enable) begin
            r_state <= OFF;
            r_cnt   <= w_act.off_eff;
            r_gate  <= 1'b0;
          end else if (tick_en & (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        OFF: begin
          // At the boundary the freshly transferred config decides the next period.
          if (w_tick_end) begin
            if (enable & (w_nxt.on_eff != '0)) begin
              r_state        <= ON;
              r_cnt          <= w_nxt.on_eff;
              r_gate         <= 1'b1;
              r_period_start <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end
          end else if (tick_en & (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        FAULT: begin
          r_cnt     <= '0;
          r_gate    <= 1'b0;
          r_faulted <= 1'b1;
          if (fault_clear) begin
            r_state   <= IDLE;
            r_faulted <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_gate  <= 1'b0;
        end
      endcase
    end
  end

  assign gate         = r_gate & ~fault;
  assign period_start = r_period_start;
  assign faulted      = r_faulted;

endmodule
